// File: rtl/param_prio_rr_arbiter_if.sv
// Request/grant bundle between bus masters and param_prio_rr_arbiter.
// The masters drive req/mode; the arbiter drives the registered grant outputs.
interface param_prio_rr_arbiter_if #(
  parameter int NUM_REQ = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic               mode;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;

  modport master (
    output mode,
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_id
  );

  modport slave (
    input  mode,
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_id
  );
endinterface

// File: rtl/param_prio_rr_arbiter.sv
// N-way arbiter with run-time fixed-priority / round-robin selection and bounded grant hold.
// Optional macro ARB_STATS_EN adds a saturating grant_count output.
module param_prio_rr_arbiter #(
  parameter  int NUM_REQ  = 8,
  parameter  int MAX_HOLD = 16,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  param_prio_rr_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]            grant_count
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] cand;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic               new_grant;

  // While granting, the current owner never competes in its own handoff.
  always_comb begin
    cand = bus.req;
    if (state_q == GRANT) begin
      cand[gnt_id_q] = 1'b0;
    end
  end

  // Loops run backwards so the last hit is the first in scan order.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    if (!bus.mode) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (cand[i]) begin
          win_found = 1'b1;
          win_id    = ID_W'(i);
        end
      end
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (cand[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
          win_found = 1'b1;
          win_id    = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    hold_cnt_d  = hold_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    new_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        new_grant = win_found;
      end
      GRANT: begin
        if (!bus.req[gnt_id_q]) begin
          if (win_found) begin
            new_grant = 1'b1;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_id_d    = '0;
            hold_cnt_d  = '0;
          end
        end else if (hold_cnt_q == HOLD_LAST && win_found) begin
          new_grant = 1'b1;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (new_grant) begin
      state_d         = GRANT;
      gnt_d           = '0;
      gnt_d[win_id]   = 1'b1;
      gnt_valid_d     = 1'b1;
      gnt_id_d        = win_id;
      hold_cnt_d      = '0;
      rr_ptr_d        = win_id;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      hold_cnt_q  <= '0;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      hold_cnt_q  <= hold_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;

`ifdef ARB_STATS_EN
  logic [15:0] grant_count_q, grant_count_d;

  always_comb begin
    grant_count_d = grant_count_q;
    if (new_grant && grant_count_q != 16'hFFFF) begin
      grant_count_d = grant_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_count_q <= '0;
    end else begin
      grant_count_q <= grant_count_d;
    end
  end

  assign grant_count = grant_count_q;
`endif

endmodule

// File: doc/param_prio_rr_arbiter.md
Name: param_prio_rr_arbiter

Overview:
N-requester arbiter; successor of the fixed 5-agent priority arbiter.
- Run-time mode select: fixed priority (index 0 highest) or round-robin.
- Grants held while the owner keeps requesting, bounded by a hold limit.
- Registered one-hot grant plus encoded grant index.
- Sits between bus masters and a shared resource (memory port or bus slave).

Parameters:
- NUM_REQ, 8, number of requesters; legal 2..32.
- MAX_HOLD, 16, max consecutive grant cycles per owner while others are pending; legal >=1.
- ID_W, $clog2(NUM_REQ), width of gnt_id; derived, not overridden.
- CNT_W, $clog2(MAX_HOLD+1), width of the hold counter; derived.

Ports:
- clock  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled only at arbitration decisions.
- req  input  NUM_REQ  active-high request per agent.
- gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle.
- gnt_valid  output  1  registered; high when any gnt bit is set (=|gnt).
- gnt_id  output  ID_W  registered index of granted agent; 0 when idle.

Behaviour:
- Reset (async): state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, rr_ptr=NUM_REQ-1.
  - Reset asserted mid-grant clears all state immediately, without waiting for a clock edge.
- States: IDLE, GRANT.
- Winner selection (combinational, from req and the mask given below):
  - mode=0: lowest set index wins.
  - mode=1: first set index scanning rr_ptr+1, rr_ptr+2, ... with wrap NUM_REQ-1 -> 0.
- IDLE:
  - req==0: stay IDLE, outputs 0.
  - Else at the edge: winner granted and state -> GRANT.
  - Winner's bit set in gnt; gnt_id=winner; gnt_valid=1; hold_cnt=0; rr_ptr=winner.
  - Latency: req high before edge k -> gnt high after edge k (1 cycle).
- GRANT, owner o. Evaluate in this order at each edge:
  1. req[o]==0 and other requests pending: regrant directly to a new winner with o masked out; no idle bubble.
  2. req[o]==0 and no other requests: -> IDLE, outputs 0.
  3. req[o]==1, hold_cnt==MAX_HOLD-1 and any other request pending: forced handoff to a new winner with o masked out; hold_cnt=0.
  4. Otherwise: keep o; hold_cnt increments, saturating at MAX_HOLD-1.
  - Net effect: a contended owner holds for exactly MAX_HOLD cycles.
  - An uncontended owner holds indefinitely.
- Every new grant (from IDLE or a handoff) sets rr_ptr=winner and hold_cnt=0.
- rr_ptr updates in both modes, so switching to round-robin continues from the last owner.
- MAX_HOLD=1: contended grants rotate every cycle.
- Mode change mid-grant: no effect on the current owner; applies at the next decision.
- Invariant: gnt is always one-hot or zero; gnt_id is consistent with gnt.
- Requests from non-owners never alter gnt except at decision points.

Optional Feature:
ARB_STATS_EN
- Defined: adds output port grant_count [15:0].
  - Increments by 1 on every new grant event: IDLE->GRANT, drop-regrant or forced handoff.
  - Continued ownership does not count.
  - Saturates at 16'hFFFF; async reset to 0.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
1. NUM_REQ=8, MAX_HOLD=4, mode=0, req=8'b0010_0100 held steady -> gnt=8'h04, gnt_id=2 one cycle after first edge; gnt=8'h20, gnt_id=5 after 4 grant cycles; then back to 8'h04 after 4 more.
2. mode=1, req=8'hFF constant from reset -> gnt_id sequence 0,1,2,...,7,0, each held 4 cycles; gnt_valid stays 1 throughout.
3. mode=1, owner 3 granted, req changes to 8'b1000_0010 (bit 3 dropped) -> next edge gnt_id=7 (first after rr_ptr=3), with no idle cycle.
4. Single requester req=8'h10 held for 20 cycles -> gnt=8'h10 for all 20 cycles, no handoff; then req=0 -> gnt=0, gnt_valid=0, gnt_id=0 next edge.
5. Reset pulse asserted mid-grant, between edges -> gnt, gnt_valid and gnt_id go 0 immediately; after release with req=8'hFF and mode=1, first grant goes to gnt_id=0.
6. ARB_STATS_EN defined, scenario 2 run for 32 grant cycles -> grant_count=8.
   - Force the count to 16'hFFFE, then 3 further grant events -> grant_count=16'hFFFF.
